dsp_pipe_reg: RTL and testbench

Parametrised multi-channel pipeline register chain for the DSP48A1-style datapath. It generalises the single-stage CE/reset operand register to:
- DEPTH stages of CHANNELS × WIDTH data;
- per-stage valid tracking;
- a synchronous flush;
- fill/primed status.

It sits on operand and result paths (A, B, D, M, P) wherever the block needs latency-matched, stallable registering.

---
 rtl/dsp_pipe_pkg.sv | 22 ++
 rtl/dsp_pipe_reg_stage.sv | 82 ++++++++
 rtl/dsp_pipe_reg.sv | 164 ++++++++++++++++
 tb/tb_dsp_pipe_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pipe_pkg.sv
// dsp_pipe_pkg
//   Shared constants and helpers for the dsp_pipe_reg register chain:
//   legal parameter limits, the FILL-width function and even parity.
//   No ports.
package dsp_pipe_pkg;

   localparam int unsigned MAX_DEPTH    = 8;
   localparam int unsigned MAX_CHANNELS = 4;
   localparam int unsigned MAX_WIDTH    = 48;

   // $clog2 that never returns less than 1, so a counter is at least 1 bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

   // Even parity: the returned bit makes the total count of ones even
   function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/dsp_pipe_reg_stage.sv
// dsp_pipe_stage
//   One register stage of the dsp_pipe_reg chain: data, valid and
//   (with DSP_PIPE_PARITY_EN defined) per-channel parity.
//   Priority per edge: RST > FLUSH > CE > hold.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   ce_i, flush_i  clock enable, synchronous invalidate
//   data_i/vld_i   sample from previous stage (or chain input)
//   par_i          parity of data_i (DSP_PIPE_PARITY_EN only)
//   data_o/vld_o   registered sample
//   par_o          registered parity (DSP_PIPE_PARITY_EN only)
module dsp_pipe_stage #(
   parameter int unsigned   W        = 18,
`ifdef DSP_PIPE_PARITY_EN
   parameter int unsigned   PW       = 1,
   parameter logic [PW-1:0] RST_PAR  = '0,
`endif
   parameter logic [W-1:0]  RST_DATA = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ce_i,
   input  logic          flush_i,
   input  logic [W-1:0]  data_i,
   input  logic          vld_i,
`ifdef DSP_PIPE_PARITY_EN
   input  logic [PW-1:0] par_i,
   output logic [PW-1:0] par_o,
`endif
   output logic [W-1:0]  data_o,
   output logic          vld_o
);

   typedef struct packed {
      logic [W-1:0]  data;
      logic          valid;
`ifdef DSP_PIPE_PARITY_EN
      logic [PW-1:0] parity;
`endif
   } stage_rec_t;

   stage_rec_t stage_q, stage_d;

   always_comb begin
      stage_d = stage_q;
      if (flush_i) begin
         // A flushed cycle still lets data advance, but never as valid
         stage_d.valid = 1'b0;
         if (ce_i) begin
            stage_d.data = data_i;
`ifdef DSP_PIPE_PARITY_EN
            stage_d.parity = par_i;
`endif
         end
      end else if (ce_i) begin
         stage_d.data  = data_i;
         stage_d.valid = vld_i;
`ifdef DSP_PIPE_PARITY_EN
         stage_d.parity = par_i;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q.data  <= RST_DATA;
         stage_q.valid <= 1'b0;
`ifdef DSP_PIPE_PARITY_EN
         stage_q.parity <= RST_PAR;
`endif
      end else begin
         stage_q <= stage_d;
      end
   end

   assign data_o = stage_q.data;
   assign vld_o  = stage_q.valid;
`ifdef DSP_PIPE_PARITY_EN
   assign par_o  = stage_q.parity;
`endif

endmodule

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg
//   DEPTH-stage, CHANNELS x WIDTH pipeline register with shared CE,
//   synchronous flush, per-stage valid and a registered fill counter.
//   DEPTH = 0 gives a combinational passthrough.
//   Optional macro DSP_PIPE_PARITY_EN adds per-channel parity carried
//   through the chain and a sticky PAR_ERR output.
// Ports:
//   CLK, RST       clock (rising edge), synchronous active-high reset
//   CE             clock enable; low holds every register
//   FLUSH          clears all stage valids and FILL
//   IN_VLD, DIN    input sample, channel 0 in the LSBs
//   DOUT, OUT_VLD  last-stage sample
//   FILL           number of valid samples in flight
//   PAR_ERR        per-channel sticky parity error (DSP_PIPE_PARITY_EN)
//   PRIMED         FILL == DEPTH
module dsp_pipe_reg
   import dsp_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH    = 18,
   parameter int unsigned      DEPTH    = 1,
   parameter int unsigned      CHANNELS = 1,
   parameter logic [WIDTH-1:0] RSTVAL   = '0
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                CE,
   input  logic                                FLUSH,
   input  logic                                IN_VLD,
   input  logic [CHANNELS*WIDTH-1:0]           DIN,
   output logic [CHANNELS*WIDTH-1:0]           DOUT,
   output logic                                OUT_VLD,
   output logic [clog2_min1(DEPTH+1)-1:0]      FILL,
`ifdef DSP_PIPE_PARITY_EN
   output logic [CHANNELS-1:0]                 PAR_ERR,
`endif
   output logic                                PRIMED
);

   localparam int unsigned DW  = CHANNELS * WIDTH;
   localparam int unsigned FW  = clog2_min1(DEPTH + 1);
   localparam int unsigned FW1 = FW + 1;

   if (DEPTH == 0) begin : g_pass

      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, RST, CE, FLUSH};

      assign DOUT    = DIN;
      assign OUT_VLD = IN_VLD;
      assign FILL    = '0;
      assign PRIMED  = 1'b1;
`ifdef DSP_PIPE_PARITY_EN
      assign PAR_ERR = '0;
`endif

   end else begin : g_pipe

      // Index 0 is the chain input; index k+1 is the output of stage k
      logic [DEPTH:0][DW-1:0] data_s;
      logic [DEPTH:0]         vld_s;

      assign data_s[0] = DIN;
      assign vld_s[0]  = IN_VLD;

`ifdef DSP_PIPE_PARITY_EN
      localparam logic [CHANNELS-1:0] RST_PAR =
         {CHANNELS{even_parity(MAX_WIDTH'(RSTVAL))}};

      logic [DEPTH:0][CHANNELS-1:0] par_s;
      logic [CHANNELS-1:0]          par_chk;
      logic [CHANNELS-1:0]          par_err_q, par_err_d;

      always_comb begin
         par_s[0] = '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            par_s[0][c] = even_parity(MAX_WIDTH'(DIN[c*WIDTH +: WIDTH]));
         end
      end
`endif

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         dsp_pipe_stage #(
            .W        (DW),
`ifdef DSP_PIPE_PARITY_EN
            .PW       (CHANNELS),
            .RST_PAR  (RST_PAR),
`endif
            .RST_DATA ({CHANNELS{RSTVAL}})
         ) u_stage (
            .clk_i   (CLK),
            .rst_i   (RST),
            .ce_i    (CE),
            .flush_i (FLUSH),
            .data_i  (data_s[k]),
            .vld_i   (vld_s[k]),
`ifdef DSP_PIPE_PARITY_EN
            .par_i   (par_s[k]),
            .par_o   (par_s[k+1]),
`endif
            .data_o  (data_s[k+1]),
            .vld_o   (vld_s[k+1])
         );
      end

      assign DOUT    = data_s[DEPTH];
      assign OUT_VLD = vld_s[DEPTH];

      // Fill counter: one extra bit so over/underflow is observable
      logic [FW-1:0] fill_q, fill_d;
      logic          primed_q, primed_d;
      logic [FW1-1:0] fill_calc;

      always_comb begin
         fill_calc = {1'b0, fill_q} + FW1'(IN_VLD) - FW1'(vld_s[DEPTH]);
         fill_d    = fill_q;
         primed_d  = primed_q;
         if (FLUSH) begin
            fill_d   = '0;
            primed_d = 1'b0;
         end else if (CE) begin
            fill_d   = fill_calc[FW-1:0];
            primed_d = (fill_calc == FW1'(DEPTH));
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            fill_q   <= '0;
            primed_q <= 1'b0;
         end else begin
            fill_q   <= fill_d;
            primed_q <= primed_d;
         end
      end

      assign FILL   = fill_q;
      assign PRIMED = primed_q;

      a_fill_range : assert property (
         @(posedge CLK) disable iff (RST)
         (CE && !FLUSH) |-> (fill_calc <= FW1'(DEPTH)));

`ifdef DSP_PIPE_PARITY_EN
      always_comb begin
         par_chk = '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            par_chk[c] = even_parity(MAX_WIDTH'(DOUT[c*WIDTH +: WIDTH]))
                         ^ par_s[DEPTH][c];
         end
         par_err_d = par_err_q;
         if (OUT_VLD) par_err_d = par_err_q | par_chk;
      end

      always_ff @(posedge CLK) begin
         if (RST) par_err_q <= '0;
         else     par_err_q <= par_err_d;
      end

      assign PAR_ERR = par_err_q;
`endif

   end

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// tb_dsp_pipe_reg
//   Directed, table-driven bench for dsp_pipe_reg (WIDTH=18, DEPTH=3,
//   CHANNELS=2, RSTVAL=0x155) plus a DEPTH=0 passthrough instance.
//   The parity sequence is compiled only with DSP_PIPE_PARITY_EN.
module tb_dsp_pipe_reg;

   localparam int unsigned W = 18;
   localparam int unsigned D = 3;
   localparam int unsigned C = 2;
   localparam logic [W-1:0] RV = 18'h155;
   localparam logic [35:0]  R  = {RV, RV};

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, ce, iv;
   logic [35:0] din, dout;
   logic        ovld;
   logic [1:0]  fill;
   logic        primed;

   logic [35:0] din0, dout0;
   logic        iv0, ovld0;
   logic [0:0]  fill0;
   logic        primed0;
`ifdef DSP_PIPE_PARITY_EN
   logic [1:0]  par_err, par_err0;
`endif

   dsp_pipe_reg #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .RSTVAL(RV)) dut (
      .CLK(clk), .RST(rst), .CE(ce), .FLUSH(flush), .IN_VLD(iv), .DIN(din),
      .DOUT(dout), .OUT_VLD(ovld), .FILL(fill),
`ifdef DSP_PIPE_PARITY_EN
      .PAR_ERR(par_err),
`endif
      .PRIMED(primed));

   dsp_pipe_reg #(.WIDTH(W), .DEPTH(0), .CHANNELS(C), .RSTVAL(RV)) dut0 (
      .CLK(clk), .RST(rst), .CE(ce), .FLUSH(flush), .IN_VLD(iv0), .DIN(din0),
      .DOUT(dout0), .OUT_VLD(ovld0), .FILL(fill0),
`ifdef DSP_PIPE_PARITY_EN
      .PAR_ERR(par_err0),
`endif
      .PRIMED(primed0));

   typedef struct {
      logic        rst, flush, ce, iv;
      logic [35:0] din;
      logic        chk_dout;
      logic [35:0] dout;
      logic        vld;
      logic [1:0]  fill;
      logic        primed;
   } vec_t;

   vec_t tv[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Distinct tag per sample, different on each channel
   function automatic logic [35:0] V(input int n);
      logic [17:0] hi, lo;
      hi = 18'(n * 16 + 1);
      lo = 18'(n * 16);
      return {hi, lo};
   endfunction

   task automatic add(input logic r, f, e, i, input logic [35:0] di,
                      input logic cd, input logic [35:0] dq,
                      input logic v, input logic [1:0] fl, input logic p);
      vec_t t;
      t = '{rst: r, flush: f, ce: e, iv: i, din: di, chk_dout: cd,
            dout: dq, vld: v, fill: fl, primed: p};
      tv.push_back(t);
   endtask

   task automatic check(input string name, input logic [63:0] act, exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef DSP_PIPE_PARITY_EN
   logic [38:0] s1v;
`endif

   initial begin
      rst = 1'b1; flush = 1'b0; ce = 1'b0; iv = 1'b0; din = '0;
      din0 = '0; iv0 = 1'b0;

      //   rst flush ce iv din    chk dout  vld fill primed
      // reset and first-sample latency
      add(1, 0, 0, 0, V(0),  1, R,     0, 0, 0);
      add(1, 0, 1, 1, V(0),  1, R,     0, 0, 0);
      add(0, 0, 1, 1, V(1),  1, R,     0, 1, 0);
      add(0, 0, 1, 1, V(2),  1, R,     0, 2, 0);
      add(0, 0, 1, 1, V(3),  1, V(1),  1, 3, 1);
      // bubbles: IN_VLD 0,1,1,1 after V3
      add(0, 0, 1, 0, V(4),  1, V(2),  1, 2, 0);
      add(0, 0, 1, 1, V(5),  1, V(3),  1, 2, 0);
      add(0, 0, 1, 1, V(6),  1, V(4),  0, 2, 0);
      add(0, 0, 1, 1, V(7),  1, V(5),  1, 3, 1);
      add(0, 0, 1, 1, V(8),  1, V(6),  1, 3, 1);
      // flush collides with a valid input; V9 must never emerge valid
      add(0, 1, 1, 1, V(9),  0, R,     0, 0, 0);
      add(0, 0, 1, 0, V(10), 0, R,     0, 0, 0);
      add(0, 0, 1, 0, V(11), 0, R,     0, 0, 0);
      add(0, 0, 1, 0, V(12), 1, V(10), 0, 0, 0);
      // refill, then stall for 4 cycles with junk on the inputs
      add(0, 0, 1, 1, V(1),  1, V(11), 0, 1, 0);
      add(0, 0, 1, 1, V(2),  1, V(12), 0, 2, 0);
      add(0, 0, 1, 1, V(3),  1, V(1),  1, 3, 1);
      add(0, 0, 0, 1, V(9),  1, V(1),  1, 3, 1);
      add(0, 0, 0, 0, V(9),  1, V(1),  1, 3, 1);
      add(0, 0, 0, 1, V(13), 1, V(1),  1, 3, 1);
      add(0, 0, 0, 1, V(14), 1, V(1),  1, 3, 1);
      add(0, 0, 1, 1, V(4),  1, V(2),  1, 3, 1);
      add(0, 0, 1, 1, V(5),  1, V(3),  1, 3, 1);
      add(0, 0, 1, 1, V(6),  1, V(4),  1, 3, 1);
      // reset wins over flush and CE mid-stream; every stage holds RSTVAL
      add(1, 1, 1, 1, V(7),  1, R,     0, 0, 0);
      add(0, 0, 0, 1, V(8),  1, R,     0, 0, 0);
      add(0, 0, 1, 0, V(1),  1, R,     0, 0, 0);
      add(0, 0, 1, 0, V(2),  1, R,     0, 0, 0);
      add(0, 0, 1, 0, V(3),  1, V(1),  0, 0, 0);

      for (int i = 0; i < tv.size(); i++) begin
         rst = tv[i].rst; flush = tv[i].flush; ce = tv[i].ce;
         iv = tv[i].iv;   din = tv[i].din;
         step();
         if (tv[i].chk_dout)
            check($sformatf("row%0d dout", i), 64'(dout), 64'(tv[i].dout));
         check($sformatf("row%0d out_vld", i), 64'(ovld),   64'(tv[i].vld));
         check($sformatf("row%0d fill", i),    64'(fill),   64'(tv[i].fill));
         check($sformatf("row%0d primed", i),  64'(primed), 64'(tv[i].primed));
      end

      // DEPTH=0: same-cycle passthrough regardless of control
      rst = 1'b1; ce = 1'b0; flush = 1'b1;
      din0 = V(5); iv0 = 1'b1;
      #1;
      check("d0 dout a",    64'(dout0),   64'(V(5)));
      check("d0 vld a",     64'(ovld0),   64'd1);
      check("d0 fill a",    64'(fill0),   64'd0);
      check("d0 primed a",  64'(primed0), 64'd1);
      step();
      rst = 1'b0; flush = 1'b0; ce = 1'b1;
      din0 = 36'hF_FFFF_FFFF; iv0 = 1'b0;
      #1;
      check("d0 dout b",    64'(dout0),   64'h0_000F_FFFF_FFFF);
      check("d0 vld b",     64'(ovld0),   64'd0);
      step();
      check("d0 primed b",  64'(primed0), 64'd1);

`ifdef DSP_PIPE_PARITY_EN
      rst = 1'b1; flush = 1'b0; ce = 1'b0; iv = 1'b0; din = '0;
      step();
      check("par reset", 64'(par_err), 64'd0);
      rst = 1'b0; ce = 1'b1; iv = 1'b1; din = {18'h3FFFF, 18'h3FFFF};
      step();
      iv = 1'b0; din = '0;
      step();
      s1v = dut.g_pipe.g_stage[1].u_stage.stage_q;
      s1v[3] = ~s1v[3];
      force dut.g_pipe.g_stage[1].u_stage.stage_q = s1v;
      step();
      release dut.g_pipe.g_stage[1].u_stage.stage_q;
      check("par vld at out",   64'(ovld),    64'd1);
      check("par err not yet",  64'(par_err), 64'd0);
      step();
      check("par err set",      64'(par_err), 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("par err sticky",   64'(par_err), 64'd1);
      check("par err depth0",   64'(par_err0), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("par err cleared",  64'(par_err), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
